regfile_reader: RTL and testbench

- Sequential read-side engine for the 32x32 register file built from register32/register32zero cells.
- On a start pulse it walks a contiguous range of register addresses through one combinational read port and streams each (address, data) pair out over a valid/ready handshake.
- Used for debug dump and bench readback of the CPU register file. It is the reader counterpart to the register write path (d/wrenable/clk).

---
 rtl/regfile_reader_pkg.sv | 17 +
 rtl/regfile_reader.sv | 101 ++++++++++
 tb/tb_regfile_reader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_reader_pkg.sv
// regfile_reader_pkg: shared state encoding, default sizes and length rule
// for the register-file dump engine.
package regfile_reader_pkg;

   localparam int WIDTH_DEF  = 32;
   localparam int ADDR_W_DEF = 5;

   // A requested length of zero selects the whole register file.
   localparam logic LEN_ZERO_IS_FULL = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      SEND  = 2'd2
   } state_e;

endpackage

// File: rtl/regfile_reader.sv
// regfile_reader: walks a contiguous range of register-file addresses and
// streams each (address, data) pair out over a valid/ready handshake.
module regfile_reader
   import regfile_reader_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [WIDTH-1:0]  rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;

   // rd_addr_q doubles as the walk cursor; it only advances into a new ISSUE,
   // so it keeps the last issued address once the dump ends.
   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      rem_d       = rem_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d   = ISSUE;
            rd_addr_d = base_addr;
            rem_d     = (LEN_ZERO_IS_FULL && length == '0) ? FULL_LEN : length;
         end
         ISSUE: begin
            state_d     = SEND;
            out_data_d  = rd_data;
            out_addr_d  = rd_addr_q;
            out_last_d  = rem_q == (ADDR_W+1)'(1);
            out_valid_d = 1'b1;
         end
         SEND: if (out_ready) begin
            out_valid_d = 1'b0;
            rem_d       = rem_q - (ADDR_W+1)'(1);
            state_d     = out_last_q ? IDLE : ISSUE;
            done_d      = out_last_q;
            rd_addr_d   = out_last_q ? rd_addr_q : rd_addr_q + ADDR_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rd_addr_q   <= '0;
         rem_q       <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         rem_q       <= rem_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   assign rd_addr   = rd_addr_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign done      = done_q;
   assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_regfile_reader.sv
// tb_regfile_reader: directed table-driven dumps plus hand-written timing,
// backpressure, busy-start and mid-dump reset sequences.
module tb_regfile_reader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  base_addr = '0;
   logic [5:0]  length = '0;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic [4:0]  out_addr;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [31:0] rf [32];
   int n_checks = 0;
   int n_pass = 0;

   regfile_reader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .length(length), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
   );

   assign rd_data = rf[rd_addr];

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  b;
      logic [5:0]  l;
      int          ec;
      logic [4:0]  el;
      logic [31:0] fd;
   } vec_t;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_dump(input logic [4:0] b, input logic [5:0] l, input int ec,
                           input logic [4:0] el, input logic [31:0] fd);
      int cnt;
      bit dn, bsy_ok, last_ok;
      logic [4:0] ea, la;
      cnt = 0; dn = 0; bsy_ok = 1; last_ok = 1; la = '0;
      out_ready = 1; base_addr = b; length = l; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 200 && !dn; c++) begin
         step();
         if (done) begin
            dn = 1;
            chk("idle_at_done", busy, 0);
         end else if (!busy) bsy_ok = 0;
         if (out_valid) begin
            ea = b + cnt[4:0];
            chk("word_addr", out_addr, ea);
            chk("word_data", out_data, cnt == 0 ? fd : rf[ea]);
            if (out_last != (cnt == ec - 1)) last_ok = 0;
            if (out_last) la = out_addr;
            cnt++;
         end
      end
      chk("word_count", cnt, ec);
      chk("done_seen", dn, 1);
      chk("busy_throughout", bsy_ok, 1);
      chk("last_only_final", last_ok, 1);
      chk("last_addr", la, el);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[5];
      logic [15:0] vmask;
      logic [31:0] sd;
      logic [4:0]  sa;
      int dstep, cnt, hold;
      bit dn;
      for (int a = 0; a < 32; a++) rf[a] = a * 17;
      vecs[0] = '{5'd1,  6'd4,  4,  5'd4,  32'h11};
      vecs[1] = '{5'd30, 6'd4,  4,  5'd1,  32'h1FE};
      vecs[2] = '{5'd0,  6'd0,  32, 5'd31, 32'h0};
      vecs[3] = '{5'd31, 6'd1,  1,  5'd31, 32'h20F};
      vecs[4] = '{5'd5,  6'd32, 32, 5'd4,  32'h55};

      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_last", out_last, 0);
      reset_n = 1;
      step();

      foreach (vecs[i]) run_dump(vecs[i].b, vecs[i].l, vecs[i].ec, vecs[i].el, vecs[i].fd);

      // Cycle-exact timing, then a start in the done cycle.
      vmask = '0; dstep = -1;
      out_ready = 1; base_addr = 5'd1; length = 6'd4; start = 1;
      for (int s = 1; s <= 9; s++) begin
         step();
         start = 0;
         if (out_valid) vmask[s] = 1'b1;
         if (done && dstep < 0) dstep = s;
      end
      chk("valid_cycles", vmask, 16'h0154);
      chk("done_cycle", dstep, 9);
      base_addr = 5'd2; length = 6'd1; start = 1;
      step();
      start = 0;
      chk("restart_busy", busy, 1);
      chk("restart_rd_addr", rd_addr, 2);
      step();
      chk("restart_valid", out_valid, 1);
      chk("restart_addr", out_addr, 2);
      chk("restart_data", out_data, 32'h22);
      chk("restart_last", out_last, 1);
      step();
      chk("restart_done", done, 1);
      step();

      // Backpressure on the second word for five cycles.
      cnt = 0; hold = 0; dn = 0; sa = '0; sd = '0;
      out_ready = 1; base_addr = 5'd10; length = 6'd3; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 60 && !dn; c++) begin
         step();
         if (done) dn = 1;
         if (out_valid) begin
            if (cnt == 1 && hold < 5) begin
               if (hold > 0) begin
                  chk("bp_addr_stable", out_addr, sa);
                  chk("bp_data_stable", out_data, sd);
               end else begin
                  sa = out_addr;
                  sd = out_data;
               end
               out_ready = 0;
               hold++;
            end else begin
               out_ready = 1;
               chk("bp_addr", out_addr, 5'd10 + cnt[4:0]);
               chk("bp_data", out_data, rf[5'd10 + cnt[4:0]]);
               cnt++;
            end
         end
      end
      out_ready = 1;
      chk("bp_count", cnt, 3);
      chk("bp_hold", hold, 5);
      chk("bp_done", dn, 1);

      // A start pulse while busy must be ignored.
      cnt = 0; dn = 0;
      base_addr = 5'd20; length = 6'd3; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 60 && !dn; c++) begin
         step();
         start = 0;
         if (done) dn = 1;
         if (out_valid) begin
            chk("busy_start_addr", out_addr, 5'd20 + cnt[4:0]);
            if (cnt == 0) begin
               start = 1; base_addr = 5'd0; length = 6'd1;
            end
            cnt++;
         end
      end
      chk("busy_start_count", cnt, 3);
      chk("busy_start_done", dn, 1);
      step();
      chk("busy_start_idle", busy, 0);

      // Asynchronous reset while the second word is pending.
      cnt = 0;
      base_addr = 5'd7; length = 6'd4; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 20 && cnt < 2; c++) begin
         step();
         if (out_valid) cnt++;
      end
      chk("rst_mid_reached", cnt, 2);
      out_ready = 0;
      #2 reset_n = 0;
      #1;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_addr", out_addr, 0);
      #2 reset_n = 1;
      step();
      chk("rst_mid_no_done", done, 0);
      chk("rst_mid_idle", busy, 0);
      run_dump(5'd3, 6'd2, 2, 5'd4, 32'h33);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
